// File: rtl/frame_buffer_scheduler.sv
// rtl/frame_buffer_scheduler.sv - triple-buffer bank scheduler between camera capture and VGA display
//
// Ports:
//   CLK_25_I           25 MHz clock
//   RST_I              synchronous active-high reset
//   ENABLE_I           capture enable (writer only; reader swaps regardless)
//   CAM_FRAME_START_I  camera start-of-frame pulse
//   CAM_PXL_VALID_I    camera pixel strobe
//   VGA_FRAME_START_I  display frame-boundary pulse (vertical blanking)
//   WR_EN_O            BRAM write enable (combinational)
//   WR_ADDR_O          pixel address within the write bank
//   WR_BANK_O          bank being written
//   RD_BANK_O          bank being displayed
//   FRAME_VALID_O      a complete frame has reached the display
//   SHORT_FRAME_O      pulse: capture restarted by an early start of frame
//   DROP_CNT_O         saturating count of completed frames overwritten before display
module frame_buffer_scheduler #(
  parameter int ADDR_W       = 16,
  parameter int FRAME_PIXELS = 19200,
  parameter int CNT_W        = 8
) (
  input  logic              CLK_25_I,
  input  logic              RST_I,
  input  logic              ENABLE_I,
  input  logic              CAM_FRAME_START_I,
  input  logic              CAM_PXL_VALID_I,
  input  logic              VGA_FRAME_START_I,
  output logic              WR_EN_O,
  output logic [ADDR_W-1:0] WR_ADDR_O,
  output logic [1:0]        WR_BANK_O,
  output logic [1:0]        RD_BANK_O,
  output logic              FRAME_VALID_O,
  output logic              SHORT_FRAME_O,
  output logic [CNT_W-1:0]  DROP_CNT_O
);

  typedef enum logic {W_WAIT_SOF, W_CAPTURE} w_state_t;

  localparam logic [ADDR_W-1:0] LAST_PIXEL = ADDR_W'(FRAME_PIXELS - 1);

  w_state_t          state;
  logic [ADDR_W-1:0] cnt;
  logic [1:0]        disp;
  logic [1:0]        wr;
  logic [1:0]        rdy;
  logic              rdy_full;
  logic [1:0]        free_bank;
  logic              commit;

  // disp, wr and rdy always form a permutation of {0,1,2}, so the third
  // index falls out of the sum (2-bit wraparound is harmless here).
  assign free_bank = 2'd3 - disp - wr;

  assign WR_EN_O   = (state == W_CAPTURE) && CAM_PXL_VALID_I;
  assign commit    = WR_EN_O && ENABLE_I && (cnt == LAST_PIXEL);
  assign WR_ADDR_O = cnt;
  assign WR_BANK_O = wr;
  assign RD_BANK_O = disp;

  always_ff @(posedge CLK_25_I) begin
    if (RST_I) begin
      state         <= W_WAIT_SOF;
      cnt           <= '0;
      disp          <= 2'd0;
      wr            <= 2'd1;
      rdy           <= 2'd2;
      rdy_full      <= 1'b0;
      FRAME_VALID_O <= 1'b0;
      SHORT_FRAME_O <= 1'b0;
      DROP_CNT_O    <= '0;
    end else begin
      SHORT_FRAME_O <= 1'b0;

      // Writer FSM
      if (state == W_WAIT_SOF) begin
        if (CAM_FRAME_START_I && ENABLE_I) begin
          state <= W_CAPTURE;
          cnt   <= '0;
        end
      end else begin
        if (!ENABLE_I) begin
          // Disabling abandons the partial frame silently.
          state <= W_WAIT_SOF;
          cnt   <= '0;
        end else if (commit) begin
          // A start of frame coinciding with the last pixel begins the
          // next capture straight away in the freshly assigned bank.
          cnt   <= '0;
          state <= CAM_FRAME_START_I ? W_CAPTURE : W_WAIT_SOF;
        end else if (CAM_FRAME_START_I) begin
          cnt           <= '0;
          SHORT_FRAME_O <= 1'b1;
        end else if (CAM_PXL_VALID_I) begin
          cnt <= cnt + ADDR_W'(1);
        end
      end

      // Bank rotation
      if (commit && VGA_FRAME_START_I) begin
        if (rdy_full) begin
          // Display takes the waiting frame, the just-finished one waits.
          disp <= rdy;
          rdy  <= wr;
          wr   <= disp;
        end else begin
          // Nothing waiting: show the just-finished frame directly.
          disp <= wr;
          wr   <= disp;
        end
        FRAME_VALID_O <= 1'b1;
      end else if (commit) begin
        rdy <= wr;
        if (rdy_full) begin
          // Undisplayed frame in rdy gets overwritten by the next capture.
          wr <= rdy;
          if (!(&DROP_CNT_O)) begin
            DROP_CNT_O <= DROP_CNT_O + CNT_W'(1);
          end
        end else begin
          wr       <= free_bank;
          rdy_full <= 1'b1;
        end
      end else if (VGA_FRAME_START_I && rdy_full) begin
        disp          <= rdy;
        rdy           <= disp;
        rdy_full      <= 1'b0;
        FRAME_VALID_O <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// tb/tb_frame_buffer_scheduler.sv - self-checking bench for frame_buffer_scheduler
module tb_frame_buffer_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sof;
  logic        pv;
  logic        vga;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [1:0]  wr_bank;
  logic [1:0]  rd_bank;
  logic        frame_valid;
  logic        short_frame;
  logic [7:0]  drop_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  // Expected {bank, address} of every BRAM write, in order.
  logic [17:0] exp_q[$];

  always #20 clk = ~clk;

  frame_buffer_scheduler #(
    .ADDR_W(16),
    .FRAME_PIXELS(4),
    .CNT_W(8)
  ) dut (
    .CLK_25_I(clk),
    .RST_I(rst),
    .ENABLE_I(en),
    .CAM_FRAME_START_I(sof),
    .CAM_PXL_VALID_I(pv),
    .VGA_FRAME_START_I(vga),
    .WR_EN_O(wr_en),
    .WR_ADDR_O(wr_addr),
    .WR_BANK_O(wr_bank),
    .RD_BANK_O(rd_bank),
    .FRAME_VALID_O(frame_valid),
    .SHORT_FRAME_O(short_frame),
    .DROP_CNT_O(drop_cnt)
  );

  // Write monitor: every BRAM write must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $error("FAIL unexpected_write: got bank %0d addr %0d, required no write", wr_bank, wr_addr);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        assert ({wr_bank, wr_addr} === e) else begin
          n_mis++;
          $error("FAIL write_addr: got bank %0d addr %0d, required bank %0d addr %0d",
                 wr_bank, wr_addr, e[17:16], e[15:0]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %0d, required %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic s, input logic p, input logic v);
    en  = e;
    sof = s;
    pv  = p;
    vga = v;
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [1:0] bank, input logic [15:0] addr, input logic s, input logic v);
    exp_q.push_back({bank, addr});
    cyc(1'b1, s, 1'b1, v);
  endtask

  task automatic frame(input logic [1:0] bank);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int a = 0; a < 4; a++) pix(bank, 16'(a), 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    en  = 1'b0;
    sof = 1'b0;
    pv  = 1'b1;
    vga = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_bank"}, 32'(wr_bank), 1);
    chk({tag, "_rd_bank"}, 32'(rd_bank), 0);
    chk({tag, "_frame_valid"}, 32'(frame_valid), 0);
    chk({tag, "_short"}, 32'(short_frame), 0);
    chk({tag, "_drop"}, 32'(drop_cnt), 0);
    rst = 1'b0;
    pv  = 1'b0;
    vga = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sof = 1'b0; pv = 1'b0; vga = 1'b0;
    @(posedge clk);
    #1;

    // Basic capture and display handoff
    do_reset("rst0");
    frame(2'd1);
    chk("commit_wr_bank", 32'(wr_bank), 2);
    chk("commit_rd_bank", 32'(rd_bank), 0);
    chk("commit_no_valid", 32'(frame_valid), 0);
    en = 1'b1; sof = 1'b0; pv = 1'b1; vga = 1'b0;
    #1;
    chk("wait_wr_en_low", 32'(wr_en), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("swap_rd_bank", 32'(rd_bank), 1);
    chk("swap_valid", 32'(frame_valid), 1);
    chk("swap_wr_bank", 32'(wr_bank), 2);

    // Two frames without display: second overwrites the first
    do_reset("rst1");
    frame(2'd1);
    frame(2'd2);
    chk("drop_wr_bank", 32'(wr_bank), 1);
    chk("drop_cnt_1", 32'(drop_cnt), 1);
    chk("drop_rd_bank", 32'(rd_bank), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("drop_swap_rd_bank", 32'(rd_bank), 2);

    // Early start of frame restarts in the same bank
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    pix(2'd1, 16'd0, 1'b0, 1'b0);
    pix(2'd1, 16'd1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("short_pulse", 32'(short_frame), 1);
    chk("short_addr", 32'(wr_addr), 0);
    chk("short_wr_bank", 32'(wr_bank), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("short_one_cycle", 32'(short_frame), 0);
    for (int a = 0; a < 4; a++) pix(2'd1, 16'(a), 1'b0, 1'b0);
    chk("short_then_commit_wr_bank", 32'(wr_bank), 0);
    chk("short_no_drop", 32'(drop_cnt), 1);

    // Commit on the same cycle as a VGA start
    do_reset("rst2");
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int a = 0; a < 3; a++) pix(2'd1, 16'(a), 1'b0, 1'b0);
    pix(2'd1, 16'd3, 1'b0, 1'b1);
    chk("both_empty_rd_bank", 32'(rd_bank), 1);
    chk("both_empty_wr_bank", 32'(wr_bank), 0);
    chk("both_empty_valid", 32'(frame_valid), 1);
    chk("both_empty_drop", 32'(drop_cnt), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("both_empty_rdy_not_full", 32'(rd_bank), 1);
    frame(2'd0);
    chk("fill_wr_bank", 32'(wr_bank), 2);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int a = 0; a < 3; a++) pix(2'd2, 16'(a), 1'b0, 1'b0);
    pix(2'd2, 16'd3, 1'b0, 1'b1);
    chk("both_full_rd_bank", 32'(rd_bank), 0);
    chk("both_full_wr_bank", 32'(wr_bank), 1);
    chk("both_full_no_drop", 32'(drop_cnt), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("both_full_rdy_kept", 32'(rd_bank), 2);

    // Start of frame on the commit cycle chains into the new bank
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int a = 0; a < 3; a++) pix(2'd1, 16'(a), 1'b0, 1'b0);
    pix(2'd1, 16'd3, 1'b1, 1'b0);
    chk("chain_no_short", 32'(short_frame), 0);
    chk("chain_wr_bank", 32'(wr_bank), 0);
    chk("chain_wr_addr", 32'(wr_addr), 0);
    for (int a = 0; a < 4; a++) pix(2'd0, 16'(a), 1'b0, 1'b0);
    chk("chain_drop", 32'(drop_cnt), 1);
    chk("chain_wr_bank2", 32'(wr_bank), 1);

    // Enable dropped mid-capture
    do_reset("rst3");
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int a = 0; a < 3; a++) pix(2'd1, 16'(a), 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_wr_bank", 32'(wr_bank), 1);
    chk("abort_no_short", 32'(short_frame), 0);
    en = 1'b1; sof = 1'b0; pv = 1'b1; vga = 1'b0;
    #1;
    chk("abort_wr_en_low", 32'(wr_en), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("abort_no_commit", 32'(wr_bank), 1);
    frame(2'd1);
    chk("abort_then_commit_wr_bank", 32'(wr_bank), 2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("disabled_swap_rd_bank", 32'(rd_bank), 1);
    chk("disabled_swap_valid", 32'(frame_valid), 1);

    // Reset mid-capture
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    pix(2'd2, 16'd0, 1'b0, 1'b0);
    pix(2'd2, 16'd1, 1'b0, 1'b0);
    do_reset("rst_mid");

    // Drop counter saturation
    for (int i = 0; i < 300; i++) begin
      frame((i % 2 == 0) ? 2'd1 : 2'd2);
      if (i == 9) chk("drop_cnt_10_frames", 32'(drop_cnt), 9);
    end
    chk("drop_cnt_saturated", 32'(drop_cnt), 255);
    chk("sat_wr_bank", 32'(wr_bank), 1);
    chk("sat_rd_bank", 32'(rd_bank), 0);

    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pending_writes", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
